// File: rtl/riscv_pkg.sv
// riscv_pkg: opcodes, ALU codes, mux encodings and controller state enum for the RV32I multicycle core
package riscv_pkg;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_SLL  = 4'b0010;
  localparam logic [3:0] ALU_SLT  = 4'b0011;
  localparam logic [3:0] ALU_SLTU = 4'b0100;
  localparam logic [3:0] ALU_XOR  = 4'b0101;
  localparam logic [3:0] ALU_SRL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_BEQ  = 4'b1000;
  localparam logic [3:0] ALU_BNE  = 4'b1001;
  localparam logic [3:0] ALU_BLT  = 4'b1010;
  localparam logic [3:0] ALU_BGE  = 4'b1011;
  localparam logic [3:0] ALU_BLTU = 4'b1100;
  localparam logic [3:0] ALU_BGEU = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b1110;
  localparam logic [3:0] ALU_AND  = 4'b1111;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_LUI, S_JALR, S_JAL, S_BRANCH, S_ALUWB
  } state_e;

  typedef enum logic [1:0] {CLS_ADD, CLS_OP, CLS_BRANCH} alu_cls_e;

  function automatic logic [2:0] imm_src(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps state class, funct3, funct7b5 and opcode onto the ALU operation code
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_cls_e   cls,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic [6:0] opcode,
  output logic [3:0] alu_control
);
  logic [3:0] op_ctl;
  logic [3:0] br_ctl;
  // arithmetic/logic ops; SUB only for R-type, funct7b5 also picks SRA over SRL
  always_comb begin
    case (funct3)
      3'b000:  op_ctl = (opcode == OP_R && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op_ctl = ALU_SLL;
      3'b010:  op_ctl = ALU_SLT;
      3'b011:  op_ctl = ALU_SLTU;
      3'b100:  op_ctl = ALU_XOR;
      3'b101:  op_ctl = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op_ctl = ALU_OR;
      default: op_ctl = ALU_AND;
    endcase
  end
  // branch comparisons; the reserved funct3 values fall back to ADD
  always_comb begin
    case (funct3)
      3'b000:  br_ctl = ALU_BEQ;
      3'b001:  br_ctl = ALU_BNE;
      3'b100:  br_ctl = ALU_BLT;
      3'b101:  br_ctl = ALU_BGE;
      3'b110:  br_ctl = ALU_BLTU;
      3'b111:  br_ctl = ALU_BGEU;
      default: br_ctl = ALU_ADD;
    endcase
  end
  assign alu_control = cls == CLS_OP ? op_ctl : cls == CLS_BRANCH ? br_ctl : ALU_ADD;
endmodule

// File: rtl/control_fsm.sv
// control_fsm: multicycle RV32I main controller sequencing fetch, decode, execute, memory and writeback
module control_fsm
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic        Cond_Chk,
  output logic [6:0]  opcode_out,
  output logic [3:0]  AluControl,
  output logic [1:0]  AluSrcA,
  output logic [1:0]  AluSrcB,
  output logic [1:0]  ResultSrc,
  output logic [2:0]  ImmSrc,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        PCSrc,
  output logic        IllegalInstr,
  output logic [3:0]  state_dbg
);
  state_e     state, next;
  alu_cls_e   cls;
  logic [6:0] op;
  logic [2:0] f3;
  logic       illegal;
  logic       unused_bits;

  assign op          = Instr[6:0];
  assign f3          = Instr[14:12];
  assign unused_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};
  assign illegal     = !(op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC})
                       || (op == OP_BRANCH && f3[2:1] == 2'b01);
  assign ImmSrc      = reset ? imm_src(op) : IMM_I;
  assign state_dbg   = state;

  alu_decoder u_alu_decoder (
    .cls        (cls),
    .funct3     (f3),
    .funct7b5   (Instr[30]),
    .opcode     (op),
    .alu_control(AluControl)
  );

  // state register; opcode is latched for the ALU while in DECODE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_RST;
      opcode_out <= '0;
    end else begin
      state <= next;
      if (state == S_DECODE) opcode_out <= op;
    end
  end

  // next state and Moore outputs; PCWrite in BRANCH is the only term that follows Cond_Chk
  always_comb begin
    next         = S_RST;
    cls          = CLS_ADD;
    AluSrcA      = SRCA_PC;
    AluSrcB      = SRCB_RS2;
    ResultSrc    = RES_ALUOUT;
    AdrSrc       = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    PCSrc        = 1'b0;
    IllegalInstr = 1'b0;
    case (state)
      S_RST: next = S_FETCH;
      S_FETCH: begin
        AluSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        next      = S_DECODE;
      end
      S_DECODE: begin
        AluSrcA      = SRCA_OLDPC;
        AluSrcB      = SRCB_IMM;
        IllegalInstr = illegal;
        case (op)
          OP_LOAD, OP_STORE: next = S_MEMADR;
          OP_R:              next = S_EXEC_R;
          OP_I:              next = S_EXEC_I;
          OP_BRANCH:         next = S_BRANCH;
          OP_JAL:            next = S_JAL;
          OP_JALR:           next = S_JALR;
          OP_LUI:            next = S_LUI;
          OP_AUIPC:          next = S_ALUWB;
          default:           next = S_FETCH;
        endcase
        if (illegal) next = S_FETCH;
      end
      S_MEMADR: begin
        AluSrcA = SRCA_RS1;
        AluSrcB = SRCB_IMM;
        next    = op == OP_LOAD ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
        next   = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc = RES_DATA;
        RegWrite  = 1'b1;
        next      = S_FETCH;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        next     = S_FETCH;
      end
      S_EXEC_R: begin
        AluSrcA = SRCA_RS1;
        cls     = CLS_OP;
        next    = S_ALUWB;
      end
      S_EXEC_I: begin
        AluSrcA = SRCA_RS1;
        AluSrcB = SRCB_IMM;
        cls     = CLS_OP;
        next    = S_ALUWB;
      end
      S_LUI: begin
        AluSrcA = SRCA_ZERO;
        AluSrcB = SRCB_IMM;
        next    = S_ALUWB;
      end
      S_JALR: begin
        AluSrcA = SRCA_RS1;
        AluSrcB = SRCB_IMM;
        next    = S_JAL;
      end
      S_JAL: begin
        AluSrcA = SRCA_OLDPC;
        AluSrcB = SRCB_FOUR;
        PCSrc   = 1'b1;
        PCWrite = 1'b1;
        next    = S_ALUWB;
      end
      S_BRANCH: begin
        AluSrcA = SRCA_RS1;
        cls     = CLS_BRANCH;
        PCSrc   = 1'b1;
        PCWrite = Cond_Chk;
        next    = S_FETCH;
      end
      S_ALUWB: begin
        RegWrite = 1'b1;
        next     = S_FETCH;
      end
      default: next = S_RST;
    endcase
  end
endmodule

// File: tb/tb_control_fsm.sv
// tb_control_fsm: randomized instruction walks checked against an instruction-level controller model
module tb_control_fsm;
  import riscv_pkg::*;

  logic        clk = 1'b1;
  logic        reset = 1'b0;
  logic [31:0] Instr = '0;
  logic        Cond_Chk = 1'b0;
  logic [6:0]  opcode_out;
  logic [3:0]  AluControl;
  logic [1:0]  AluSrcA, AluSrcB, ResultSrc;
  logic [2:0]  ImmSrc;
  logic        AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, PCSrc, IllegalInstr;
  logic [3:0]  state_dbg;

  int n_chk = 0;
  int n_fail = 0;
  state_e walk_q[$];
  logic [3:0] op_tbl [8] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hE, 4'hF};
  logic [3:0] br_tbl [8] = '{4'h8, 4'h9, 4'h0, 4'h0, 4'hA, 4'hB, 4'hC, 4'hD};
  logic [6:0] op_pool [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

  control_fsm dut (
    .clk(clk), .reset(reset), .Instr(Instr), .Cond_Chk(Cond_Chk), .opcode_out(opcode_out),
    .AluControl(AluControl), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .ResultSrc(ResultSrc),
    .ImmSrc(ImmSrc), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .PCSrc(PCSrc), .IllegalInstr(IllegalInstr), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  function automatic logic [19:0] dut_out();
    return {AluControl, AluSrcA, AluSrcB, ResultSrc, ImmSrc, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, PCSrc, IllegalInstr};
  endfunction

  function automatic logic is_legal(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    op = i[6:0];
    f3 = i[14:12];
    if (op == 7'h63) return !(f3 == 3'd2 || f3 == 3'd3);
    return op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h6F, 7'h67, 7'h37, 7'h17};
  endfunction

  function automatic logic [19:0] model_out(input state_e s, input logic [31:0] i, input logic c);
    logic [3:0] alu;
    logic [1:0] a, b, r;
    logic [2:0] imm, f3;
    logic [6:0] op;
    logic adr, irw, pcw, mw, rw, pcs, ill;
    op = i[6:0];
    f3 = i[14:12];
    alu = 0; a = 0; b = 0; r = 0;
    {adr, irw, pcw, mw, rw, pcs, ill} = '0;
    imm = op == 7'h23 ? 3'd1 : op == 7'h63 ? 3'd2 : op == 7'h6F ? 3'd3 : (op == 7'h37 || op == 7'h17) ? 3'd4 : 3'd0;
    case (s)
      S_FETCH:    begin b = 2; r = 2; irw = 1; pcw = 1; end
      S_DECODE:   begin a = 1; b = 1; ill = !is_legal(i); end
      S_MEMADR:   begin a = 2; b = 1; end
      S_MEMREAD:  adr = 1;
      S_MEMWB:    begin r = 1; rw = 1; end
      S_MEMWRITE: begin adr = 1; mw = 1; end
      S_EXEC_R:   begin a = 2; alu = f3 == 0 && i[30] ? 4'h1 : f3 == 5 && i[30] ? 4'h7 : op_tbl[f3]; end
      S_EXEC_I:   begin a = 2; b = 1; alu = f3 == 5 && i[30] ? 4'h7 : op_tbl[f3]; end
      S_LUI:      begin a = 3; b = 1; end
      S_JALR:     begin a = 2; b = 1; end
      S_JAL:      begin a = 1; b = 2; pcs = 1; pcw = 1; end
      S_BRANCH:   begin a = 2; pcs = 1; pcw = c; alu = br_tbl[f3]; end
      S_ALUWB:    rw = 1;
      default:    ;
    endcase
    return {alu, a, b, r, imm, adr, irw, pcw, mw, rw, pcs, ill};
  endfunction

  task automatic build_walk(input logic [31:0] i);
    walk_q = {S_FETCH, S_DECODE};
    if (!is_legal(i)) return;
    case (i[6:0])
      7'h03: walk_q = {walk_q, S_MEMADR, S_MEMREAD, S_MEMWB};
      7'h23: walk_q = {walk_q, S_MEMADR, S_MEMWRITE};
      7'h33: walk_q = {walk_q, S_EXEC_R, S_ALUWB};
      7'h13: walk_q = {walk_q, S_EXEC_I, S_ALUWB};
      7'h63: walk_q = {walk_q, S_BRANCH};
      7'h6F: walk_q = {walk_q, S_JAL, S_ALUWB};
      7'h67: walk_q = {walk_q, S_JALR, S_JAL, S_ALUWB};
      7'h37: walk_q = {walk_q, S_LUI, S_ALUWB};
      default: walk_q = {walk_q, S_ALUWB};
    endcase
  endtask

  task automatic run_instr(input string tag, input logic [31:0] i, input logic c);
    logic [19:0] exp_v;
    Instr = i;
    Cond_Chk = c;
    build_walk(i);
    foreach (walk_q[k]) begin
      @(negedge clk);
      n_chk++;
      if (state_dbg !== walk_q[k]) begin
        n_fail++;
        $display("FAIL %s step %0d state: got %0d want %0d (instr %h)", tag, k, state_dbg, walk_q[k], i);
      end
      exp_v = model_out(walk_q[k], i, c);
      n_chk++;
      if (dut_out() !== exp_v) begin
        n_fail++;
        $display("FAIL %s step %0d outputs: got %h want %h (instr %h cond %0d)", tag, k, dut_out(), exp_v, i, c);
      end
      @(posedge clk);
    end
    #1;
    n_chk++;
    if (state_dbg !== S_FETCH) begin
      n_fail++;
      $display("FAIL %s return: state got %0d want %0d", tag, state_dbg, S_FETCH);
    end
    n_chk++;
    if (opcode_out !== i[6:0]) begin
      n_fail++;
      $display("FAIL %s opcode_out: got %h want %h", tag, opcode_out, i[6:0]);
    end
  endtask

  task automatic check_quiet(input string tag);
    n_chk++;
    if (state_dbg !== S_RST || dut_out() !== 20'h0 || opcode_out !== 7'h0) begin
      n_fail++;
      $display("FAIL %s: state %0d outputs %h opcode_out %h, want RST and all zero", tag, state_dbg, dut_out(), opcode_out);
    end
  endtask

  task automatic test_reset();
    Instr = 32'h0000_6063;
    Cond_Chk = 1'b1;
    #2 check_quiet("reset_low_t2");
    @(negedge clk);
    Instr = $urandom();
    check_quiet("reset_low_t5");
    #10 reset = 1'b1;
    #1 check_quiet("reset_release");
    @(posedge clk);
  endtask

  task automatic test_rtype();
    run_instr("r_add", 32'h00A5_8633, 1'b0);
    run_instr("r_sub", 32'h40A5_8633, 1'b0);
    run_instr("r_sra", 32'h40A5_D633, 1'b1);
  endtask

  task automatic test_branch();
    run_instr("beq_taken", 32'h0000_0063, 1'b1);
    run_instr("bne_not_taken", 32'h0000_1063, 1'b0);
    run_instr("bgeu_taken", 32'h0000_7063, 1'b1);
  endtask

  task automatic test_mem();
    run_instr("load", 32'h0002_A303, 1'b0);
    run_instr("store", 32'h0062_A223, 1'b1);
  endtask

  task automatic test_jumps();
    run_instr("jalr", 32'h0002_80E7, 1'b0);
    run_instr("jal", 32'h0080_00EF, 1'b0);
    run_instr("lui", 32'h1234_5537, 1'b0);
    run_instr("auipc", 32'h0000_1517, 1'b1);
    run_instr("srai", 32'h4030_D513, 1'b0);
  endtask

  task automatic test_illegal();
    run_instr("illegal_7f", 32'h0000_007F, 1'b1);
    run_instr("illegal_br010", 32'h0000_2063, 1'b1);
    run_instr("illegal_br011", 32'h0000_3063, 1'b1);
  endtask

  task automatic test_reset_mid();
    Instr = 32'h00A5_8633;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    n_chk++;
    if (state_dbg !== S_EXEC_R) begin
      n_fail++;
      $display("FAIL reset_mid pre: state got %0d want %0d", state_dbg, S_EXEC_R);
    end
    reset = 1'b0;
    #1 check_quiet("reset_mid_async");
    @(posedge clk);
    #1 check_quiet("reset_mid_held");
    reset = 1'b1;
    @(posedge clk);
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int n = 0; n < 60; n++) begin
      r = $urandom();
      run_instr("random", {r[31:7], op_pool[$urandom_range(9)]}, 1'($urandom_range(1)));
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_branch();
    test_mem();
    test_jumps();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
